// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_port_arb_pkg;

   localparam int unsigned REQ_N      = 2;
   localparam int unsigned RD_LATENCY = 2;
   localparam int unsigned LOCK_MAX   = 3;
   localparam int unsigned LOCK_CNT_W = 2;
   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned WADDR_W    = ADDR_W - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   // Read-response tag carried down the latency pipe.
   typedef struct packed {
      logic valid;
      logic id;
   } rsp_tag_t;

   function automatic logic [REQ_N-1:0] id_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/arb_rsp_pipe.sv
// Fixed-depth shift register of {valid,id} tags matching the memory read latency.
module arb_rsp_pipe
   import mem_port_arb_pkg::*;
#(
   parameter int unsigned DEPTH = RD_LATENCY
)
(
   input  logic     clk,
   input  logic     rst,
   input  rsp_tag_t tag_in,
   output rsp_tag_t tag_out
);

   rsp_tag_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arb.sv
// Two-requester arbiter onto a single-ported data memory with 2-cycle read latency.
// Optional locked (multi-beat) ownership is enabled by defining MEM_ARB_LOCK_EN.
module mem_port_arb
   import mem_port_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [REQ_N-1:0]   reqValid,
   input  logic [REQ_N-1:0]   reqWEn,
   input  logic [REQ_N-1:0]   reqLock,
   input  logic [ADDR_W-1:0]  reqAddr0,
   input  logic [ADDR_W-1:0]  reqAddr1,
   input  logic [DATA_W-1:0]  reqWData0,
   input  logic [DATA_W-1:0]  reqWData1,
   output logic [REQ_N-1:0]   gnt,
   output logic [REQ_N-1:0]   rspValid,
   output logic [DATA_W-1:0]  rspData,
   output logic [WADDR_W-1:0] memRAddr,
   input  logic [DATA_W-1:0]  memRData,
   output logic               memWEn,
   output logic [WADDR_W-1:0] memWAddr,
   output logic [DATA_W-1:0]  memWData
);

   arb_state_t         state;
   logic               last_winner;
   logic [WADDR_W-1:0] raddr_q;
   logic               gnt_any;
   logic               gnt_id;
   logic               sel_we;
   logic [WADDR_W-1:0] sel_waddr;
   logic               rd_gnt;
   logic               wr_gnt;
   rsp_tag_t           rsp_tag;
   logic               unused_bits;

`ifdef MEM_ARB_LOCK_EN
   logic [LOCK_CNT_W-1:0] lock_cnt;
   logic                  sel_lock;
   assign sel_lock    = reqLock[gnt_id];
   assign unused_bits = ^{reqAddr0[0], reqAddr1[0]};
`else
   assign unused_bits = ^{reqAddr0[0], reqAddr1[0], reqLock};
`endif

   // Grant decision: owner-only while locked, otherwise lone requester or the non-last winner.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (&reqValid) begin
                  gnt_any = 1'b1;
                  gnt_id  = ~last_winner;
               end else if (reqValid[0]) begin
                  gnt_any = 1'b1;
                  gnt_id  = 1'b0;
               end else if (reqValid[1]) begin
                  gnt_any = 1'b1;
                  gnt_id  = 1'b1;
               end
            end
            OWN0: begin
               gnt_any = reqValid[0];
               gnt_id  = 1'b0;
            end
            OWN1: begin
               gnt_any = reqValid[1];
               gnt_id  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign gnt       = gnt_any ? id_onehot(gnt_id) : '0;
   assign sel_we    = reqWEn[gnt_id];
   assign sel_waddr = gnt_id ? reqAddr1[ADDR_W-1:1] : reqAddr0[ADDR_W-1:1];
   assign rd_gnt    = gnt_any & ~sel_we;
   assign wr_gnt    = gnt_any & sel_we;

   assign memRAddr = rd_gnt ? sel_waddr : raddr_q;
   assign memWEn   = wr_gnt;
   assign memWAddr = sel_waddr;
   assign memWData = gnt_id ? reqWData1 : reqWData0;

   // Ownership FSM, round-robin history and read-address hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_winner <= 1'b1;
         raddr_q     <= '0;
`ifdef MEM_ARB_LOCK_EN
         lock_cnt    <= '0;
`endif
      end else begin
         raddr_q <= memRAddr;
         if (gnt_any) last_winner <= gnt_id;
`ifdef MEM_ARB_LOCK_EN
         case (state)
            IDLE: begin
               if (gnt_any && sel_lock) begin
                  state    <= gnt_id ? OWN1 : OWN0;
                  lock_cnt <= '0;
               end
            end
            OWN0, OWN1: begin
               if (!gnt_any || !sel_lock) begin
                  state <= IDLE;
               end else if (lock_cnt == LOCK_CNT_W'(LOCK_MAX - 1)) begin
                  // The locked beat that brings the count to LOCK_MAX ends ownership.
                  state    <= IDLE;
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
`else
         state <= IDLE;
`endif
      end
   end

   arb_rsp_pipe #(.DEPTH(RD_LATENCY)) u_rsp_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  ({rd_gnt, gnt_id}),
      .tag_out (rsp_tag)
   );

   assign rspValid = (rsp_tag.valid && !rst) ? id_onehot(rsp_tag.id) : '0;
   assign rspData  = memRData;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus random traffic vs. a behavioural model.
module tb_mem_port_arb;

`ifdef MEM_ARB_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif
   localparam int MAX_LOCKED_BEATS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  reqValid, reqWEn, reqLock;
   logic [15:0] reqAddr0, reqAddr1, reqWData0, reqWData1;
   logic [1:0]  gnt, rspValid;
   logic [15:0] rspData;
   logic [14:0] memRAddr;
   logic [15:0] memRData;
   logic        memWEn;
   logic [14:0] memWAddr;
   logic [15:0] memWData;

   always #5 clk = ~clk;

   mem_port_arb dut (
      .clk(clk), .rst(rst),
      .reqValid(reqValid), .reqWEn(reqWEn), .reqLock(reqLock),
      .reqAddr0(reqAddr0), .reqAddr1(reqAddr1),
      .reqWData0(reqWData0), .reqWData1(reqWData1),
      .gnt(gnt), .rspValid(rspValid), .rspData(rspData),
      .memRAddr(memRAddr), .memRData(memRData),
      .memWEn(memWEn), .memWAddr(memWAddr), .memWData(memWData)
   );

   // Environment memory: initial contents are a fixed pattern, overwritten by DUT writes.
   bit          env_wv [32768];
   logic [15:0] env_wd [32768];
   logic [15:0] rd_d1;

   always @(posedge clk) begin
      if (memWEn === 1'b1) begin
         env_wv[memWAddr] <= 1'b1;
         env_wd[memWAddr] <= memWData;
      end
      rd_d1    <= env_wv[memRAddr] ? env_wd[memRAddr] : (16'(memRAddr) ^ 16'h5A5A);
      memRData <= rd_d1;
   end

   // Reference model state
   bit          ref_wv [32768];
   logic [15:0] ref_wd [32768];
   typedef struct { int due; bit id; logic [15:0] data; } exp_rsp_t;
   exp_rsp_t    rsp_q [$];
   int          owner = -1;
   int          run   = 0;
   bit          lw    = 1'b1;
   bit          rd_known = 1'b0;
   logic [14:0] rd_last;
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [15:0] ref_read(input logic [14:0] wa);
      return ref_wv[wa] ? ref_wd[wa] : (16'(wa) ^ 16'h5A5A);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive, predict, compare, then advance the model.
   task automatic cycle(input logic r, input logic [1:0] v, input logic [1:0] we,
                        input logic [1:0] lk, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1);
      int          g;
      logic [1:0]  eg;
      logic [15:0] ea, ed;
      logic        ewe;
      logic [1:0]  ersp;
      logic [15:0] erd;
      @(negedge clk);
      rst = r; reqValid = v; reqWEn = we; reqLock = lk;
      reqAddr0 = a0; reqAddr1 = a1; reqWData0 = d0; reqWData1 = d1;
      #1;
      g = -1;
      if (!r) begin
         if (owner >= 0) begin
            if (v[owner]) g = owner;
         end else if (v == 2'b11) g = lw ? 0 : 1;
         else if (v[0]) g = 0;
         else if (v[1]) g = 1;
      end
      eg  = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
      ea  = (g == 1) ? a1 : a0;
      ed  = (g == 1) ? d1 : d0;
      ewe = (g >= 0) ? we[g] : 1'b0;
      chk("gnt", gnt, eg);
      chk("memWEn", memWEn, ewe);
      if (ewe) begin
         chk("memWAddr", memWAddr, ea >> 1);
         chk("memWData", memWData, ed);
      end
      if (g >= 0 && !ewe) begin
         rd_known = 1'b1;
         rd_last  = ea[15:1];
      end
      if (rd_known) chk("memRAddr", memRAddr, rd_last);
      ersp = 2'b00;
      erd  = 16'h0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
         if (!r) begin
            ersp = rsp_q[0].id ? 2'b10 : 2'b01;
            erd  = rsp_q[0].data;
         end
         void'(rsp_q.pop_front());
      end
      chk("rspValid", rspValid, ersp);
      if (ersp != 2'b00) chk("rspData", rspData, erd);
      @(posedge clk);
      if (r) begin
         owner = -1; run = 0; lw = 1'b1; rd_known = 1'b0;
         rsp_q.delete();
      end else if (g >= 0) begin
         lw = g[0];
         if (ewe) begin
            ref_wv[ea[15:1]] = 1'b1;
            ref_wd[ea[15:1]] = ed;
         end else begin
            rsp_q.push_back('{due: cyc + 2, id: g[0], data: ref_read(ea[15:1])});
         end
         if (LOCK_ON && owner < 0) begin
            if (lk[g]) begin owner = g; run = 1; end
         end else if (LOCK_ON && lk[g] && (run + 1) < MAX_LOCKED_BEATS) begin
            run++;
         end else begin
            owner = -1;
         end
      end else begin
         owner = -1;
      end
      cyc++;
   endtask

   initial begin
      rst = 1'b1; reqValid = '0; reqWEn = '0; reqLock = '0;
      reqAddr0 = '0; reqAddr1 = '0; reqWData0 = '0; reqWData1 = '0;

      // Reset with both requesting: no grants, no responses.
      repeat (3) cycle(1'b1, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);

      // Simultaneous reads after reset: requester 0 first, then 1, responses in order.
      cycle(1'b0, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
      cycle(1'b0, 2'b10, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
      repeat (3) cycle(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

      // Lone write from requester 1 to odd byte address, then read it back.
      cycle(1'b0, 2'b10, 2'b10, 2'b00, 16'h0000, 16'h0031, 16'h0, 16'hBEEF);
      repeat (2) cycle(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      cycle(1'b0, 2'b01, 2'b00, 2'b00, 16'h0030, 16'h0, 16'h0, 16'h0);
      repeat (3) cycle(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

      // Two-beat locked read by requester 0 while requester 1 keeps asking.
      cycle(1'b1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      cycle(1'b0, 2'b11, 2'b00, 2'b01, 16'h0041, 16'h0050, 16'h0, 16'h0);
      cycle(1'b0, 2'b11, 2'b00, 2'b00, 16'h0043, 16'h0050, 16'h0, 16'h0);
      repeat (3) cycle(1'b0, 2'b11, 2'b00, 2'b00, 16'h0044, 16'h0052, 16'h0, 16'h0);
      repeat (3) cycle(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

      // Lock held for 6 cycles: forced release after 4 locked beats.
      cycle(1'b1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < 6; i++)
         cycle(1'b0, 2'b11, 2'b00, 2'b01, 16'(16'h0100 + 2 * i), 16'h0200, 16'h0, 16'h0);
      repeat (2) cycle(1'b0, 2'b11, 2'b00, 2'b00, 16'h0110, 16'h0202, 16'h0, 16'h0);
      repeat (3) cycle(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

      // Read in flight when reset hits is dropped; first tie afterwards goes to requester 0.
      cycle(1'b0, 2'b01, 2'b00, 2'b00, 16'h0060, 16'h0, 16'h0, 16'h0);
      cycle(1'b1, 2'b11, 2'b00, 2'b00, 16'h0062, 16'h0064, 16'h0, 16'h0);
      repeat (2) cycle(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      cycle(1'b0, 2'b11, 2'b00, 2'b00, 16'h0066, 16'h0068, 16'h0, 16'h0);
      repeat (3) cycle(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

      // Random traffic on a small address window so reads hit earlier writes.
      for (int i = 0; i < 800; i++) begin
         logic [1:0] lk;
         lk[0] = ($urandom_range(0, 3) != 0);
         lk[1] = ($urandom_range(0, 3) != 0);
         cycle(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), lk,
               16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
               16'($urandom), 16'($urandom));
      end
      repeat (4) cycle(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
